// File: rtl/rpsc_pkg.sv
// Shared state encoding, timing defaults and helpers for the RPSC HV sequencer.
package rpsc_pkg;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_FAN      = 4'd1,
        ST_G1       = 4'd2,
        ST_CA       = 4'd3,
        ST_G2       = 4'd4,
        ST_ANODE    = 4'd5,
        ST_RUN      = 4'd6,
        ST_SHUTDOWN = 4'd7,
        ST_FAULT    = 4'd8
    } rpsc_state_e;

    localparam int unsigned DEF_TIMEOUT  = 1000;
    localparam int unsigned DEF_SETTLE   = 100;
    localparam int unsigned DEF_DOWN_DLY = 50;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Timer counts load..0 inclusive, so an N-cycle window loads N-1.
    function automatic int unsigned load_of(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

    // Thermometer of enables held on in state s (bit 0 = fan ... bit 4 = anode).
    function automatic logic [4:0] stage_mask(input rpsc_state_e s);
        logic [4:0] m;
        case (s)
            ST_FAN:           m = 5'b00001;
            ST_G1:            m = 5'b00011;
            ST_CA:            m = 5'b00111;
            ST_G2:            m = 5'b01111;
            ST_ANODE, ST_RUN: m = 5'b11111;
            default:          m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rpsc_step_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module rpsc_step_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rpsc_hv_sequencer.sv
// RPSC high-voltage power sequencer: staged power-up with ok/settle supervision,
// timed orderly shutdown and latched fault.
module rpsc_hv_sequencer
    import rpsc_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned SETTLE   = DEF_SETTLE,
    parameter int unsigned DOWN_DLY = DEF_DOWN_DLY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       fan_ok,
    input  logic       g1_ok,
    input  logic       ca_ok,
    input  logic       g2_ok,
    input  logic       anode_ok,
    input  logic       an_hv_ready,
    input  logic       rf_perm,
    output logic       fan_on,
    output logic       g1_on,
    output logic       ca_on,
    output logic       g2_on,
    output logic       anode_on,
    output logic       rf_enable,
    output logic       fault,
    output logic [3:0] state
);

    localparam int unsigned CW = $clog2(max3(TIMEOUT, SETTLE, DOWN_DLY) + 1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(load_of(TIMEOUT));
    localparam logic [CW-1:0] SETTLE_LD  = CW'(load_of(SETTLE));
    localparam logic [CW-1:0] DOWN_LD    = CW'(load_of(DOWN_DLY));

    rpsc_state_e   state_q, state_d;
    logic          settling_q, settling_d;
    logic [4:0]    en_q, en_d;
    logic          rf_enable_q, rf_enable_d;
    logic          fault_q, fault_d;

    logic          tmr_load, tmr_clear, tmr_done;
    logic [CW-1:0] tmr_val;

    logic [4:0]    ok_vec, cur_mask, cur_bit, lower_mask;
    logic          cur_ok, lower_bad;

    assign ok_vec     = {anode_ok, g2_ok, ca_ok, g1_ok, fan_ok};
    assign cur_mask   = stage_mask(state_q);
    assign cur_bit    = cur_mask ^ (cur_mask >> 1);
    assign lower_mask = cur_mask & ~cur_bit;
    assign cur_ok     = |(ok_vec & cur_bit);
    assign lower_bad  = |(lower_mask & ~ok_vec);

    rpsc_step_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        settling_d = settling_q;
        en_d       = en_q;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_val    = '0;
        case (state_q)
            ST_OFF: begin
                if (start) begin
                    state_d    = ST_FAN;
                    settling_d = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_val    = TIMEOUT_LD;
                end
            end
            ST_FAN, ST_G1, ST_CA, ST_G2, ST_ANODE: begin
                // Fault checks come first so a simultaneous stop cannot mask them.
                if (lower_bad || (!cur_ok && (settling_q || tmr_done))) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d  = ST_SHUTDOWN;
                    tmr_load = 1'b1;
                    tmr_val  = DOWN_LD;
                end else if (!settling_q) begin
                    if (cur_ok) begin
                        settling_d = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = SETTLE_LD;
                    end
                end else if (tmr_done) begin
                    state_d    = rpsc_state_e'(state_q + 4'd1);
                    settling_d = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_val    = TIMEOUT_LD;
                end
            end
            ST_RUN: begin
                if (~&ok_vec) begin
                    state_d = ST_FAULT;
                end else if (stop) begin
                    state_d  = ST_SHUTDOWN;
                    tmr_load = 1'b1;
                    tmr_val  = DOWN_LD;
                end
            end
            ST_SHUTDOWN: begin
                // Enables stay a contiguous thermometer, so a right shift drops the highest.
                if (en_q == '0) begin
                    state_d = ST_OFF;
                end else if (tmr_done) begin
                    en_d     = en_q >> 1;
                    tmr_load = 1'b1;
                    tmr_val  = DOWN_LD;
                end
            end
            ST_FAULT: begin
                if (stop) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase

        if (state_d != ST_SHUTDOWN) begin
            en_d = stage_mask(state_d);
        end
        if (state_d == ST_OFF || state_d == ST_FAULT) begin
            tmr_clear  = 1'b1;
            settling_d = 1'b0;
        end
        rf_enable_d = (state_d == ST_RUN) && rf_perm && an_hv_ready;
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OFF;
            settling_q  <= 1'b0;
            en_q        <= '0;
            rf_enable_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            settling_q  <= settling_d;
            en_q        <= en_d;
            rf_enable_q <= rf_enable_d;
            fault_q     <= fault_d;
        end
    end

    assign fan_on    = en_q[0];
    assign g1_on     = en_q[1];
    assign ca_on     = en_q[2];
    assign g2_on     = en_q[3];
    assign anode_on  = en_q[4];
    assign rf_enable = rf_enable_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Scoreboard bench for rpsc_hv_sequencer: expected output changes are queued with
// their cycle stamp; a monitor checks every change of the registered outputs.
module tb_rpsc_hv_sequencer;
    import rpsc_pkg::*;

    localparam int unsigned TO = 20;
    localparam int unsigned ST = 5;
    localparam int unsigned DD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       an_hv_ready = 1'b1;
    logic       rf_perm = 1'b1;
    logic [4:0] ok_plant = '0;
    logic [4:0] ok_en = '1;
    logic [4:0] ok_in;
    logic       fan_on, g1_on, ca_on, g2_on, anode_on, rf_enable, fault;
    logic [3:0] state;
    logic [4:0] en_v;
    logic [10:0] snap;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        mon_en = 1'b0;

    typedef struct {
        logic [10:0] snap;
        int unsigned cyc;
    } exp_t;
    exp_t  exp_q[$];
    string name_q[$];

    assign ok_in = ok_plant & ok_en;
    assign en_v  = {anode_on, g2_on, ca_on, g1_on, fan_on};
    assign snap  = {state, en_v, rf_enable, fault};

    rpsc_hv_sequencer #(.TIMEOUT(TO), .SETTLE(ST), .DOWN_DLY(DD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .fan_ok      (ok_in[0]),
        .g1_ok       (ok_in[1]),
        .ca_ok       (ok_in[2]),
        .g2_ok       (ok_in[3]),
        .anode_ok    (ok_in[4]),
        .an_hv_ready (an_hv_ready),
        .rf_perm     (rf_perm),
        .fan_on      (fan_on),
        .g1_on       (g1_on),
        .ca_on       (ca_on),
        .g2_on       (g2_on),
        .anode_on    (anode_on),
        .rf_enable   (rf_enable),
        .fault       (fault),
        .state       (state)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Plant model: each stage ok follows its enable by three cycles.
    initial begin : plant
        logic [2:0] hist [5];
        for (int i = 0; i < 5; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                hist[i]     = {hist[i][1:0], en_v[i]};
                ok_plant[i] = hist[i][2];
            end
        end
    end

    function automatic logic [10:0] mk(input logic [3:0] s, input logic [4:0] e,
                                       input logic r, input logic f);
        return {s, e, r, f};
    endfunction

    task automatic push(input string nm, input logic [10:0] s, input int unsigned c);
        exp_t e;
        e.snap = s;
        e.cyc  = c;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int unsigned limit);
        for (int i = 0; i < int'(limit) && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: actual %0d events pending (next %s), required 0",
                     exp_q.size(), name_q[0]);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic push_powerup(input string tag, input int unsigned b, input int unsigned n);
        if (n > 0) push({tag, "_fan"},   mk(ST_FAN,   5'b00001, 1'b0, 1'b0), b);
        if (n > 1) push({tag, "_g1"},    mk(ST_G1,    5'b00011, 1'b0, 1'b0), b + 8);
        if (n > 2) push({tag, "_ca"},    mk(ST_CA,    5'b00111, 1'b0, 1'b0), b + 16);
        if (n > 3) push({tag, "_g2"},    mk(ST_G2,    5'b01111, 1'b0, 1'b0), b + 24);
        if (n > 4) push({tag, "_anode"}, mk(ST_ANODE, 5'b11111, 1'b0, 1'b0), b + 32);
        if (n > 5) push({tag, "_run"},   mk(ST_RUN,   5'b11111, 1'b1, 1'b0), b + 40);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stop_to_off(input string nm);
        push(nm, mk(ST_OFF, 5'b00000, 1'b0, 1'b0), cyc + 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain(5);
        repeat (5) tick();
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        wait (mon_en);
        forever begin
            @(snap);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: actual state=%0d en=%b rf=%b fault=%b cyc=%0d, required no change",
                         snap[10:7], snap[6:2], snap[1], snap[0], cyc);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (snap !== e.snap || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL %s: actual state=%0d en=%b rf=%b fault=%b cyc=%0d, required state=%0d en=%b rf=%b fault=%b cyc=%0d",
                             nm, snap[10:7], snap[6:2], snap[1], snap[0], cyc,
                             e.snap[10:7], e.snap[6:2], e.snap[1], e.snap[0], e.cyc);
                end
            end
        end
    end

    initial begin : stim
        int unsigned b;
        int unsigned s;
        #1 reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (snap !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_state: actual %b, required %b", snap, 11'd0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Full power-up to RUN; a start pulse while running must be ignored.
        b = cyc + 1;
        push_powerup("up", b, 6);
        pulse_start();
        drain(60);
        pulse_start();
        repeat (3) tick();

        // One-cycle g1_ok drop in RUN.
        push("run_g1_drop", mk(ST_FAULT, 5'b00000, 1'b0, 1'b1), cyc + 1);
        ok_en[1] = 1'b0;
        tick();
        ok_en[1] = 1'b1;
        drain(5);
        stop_to_off("fault_clear1");

        // ca_ok never returns: timeout TO cycles after ca_on rises.
        ok_en[2] = 1'b0;
        b = cyc + 1;
        push_powerup("to", b, 3);
        push("ca_timeout", mk(ST_FAULT, 5'b00000, 1'b0, 1'b1), b + 16 + TO);
        pulse_start();
        drain(60);
        ok_en[2] = 1'b1;
        stop_to_off("fault_clear2");

        // Orderly shutdown from RUN.
        b = cyc + 1;
        push_powerup("sd", b, 6);
        pulse_start();
        drain(60);
        s = cyc + 1;
        push("sd_enter", mk(ST_SHUTDOWN, 5'b11111, 1'b0, 1'b0), s);
        push("sd_anode", mk(ST_SHUTDOWN, 5'b01111, 1'b0, 1'b0), s + DD);
        push("sd_g2",    mk(ST_SHUTDOWN, 5'b00111, 1'b0, 1'b0), s + 2 * DD);
        push("sd_ca",    mk(ST_SHUTDOWN, 5'b00011, 1'b0, 1'b0), s + 3 * DD);
        push("sd_g1",    mk(ST_SHUTDOWN, 5'b00001, 1'b0, 1'b0), s + 4 * DD);
        push("sd_fan",   mk(ST_SHUTDOWN, 5'b00000, 1'b0, 1'b0), s + 5 * DD);
        push("sd_off",   mk(ST_OFF,      5'b00000, 1'b0, 1'b0), s + 5 * DD + 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain(40);
        repeat (5) tick();

        // Asynchronous reset while in G2.
        b = cyc + 1;
        push_powerup("rst", b, 4);
        pulse_start();
        drain(40);
        tick();
        #1;
        push("async_reset", mk(ST_OFF, 5'b00000, 1'b0, 1'b0), cyc);
        reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        drain(3);
        tick();

        // Restart after reset, then stop together with a fan_ok drop in G1.
        b = cyc + 1;
        push_powerup("re", b, 2);
        push("stop_vs_fault", mk(ST_FAULT, 5'b00000, 1'b0, 1'b1), b + 10);
        pulse_start();
        for (int i = 0; i < 40 && cyc < b + 9; i++) tick();
        ok_en[0] = 1'b0;
        stop     = 1'b1;
        tick();
        stop     = 1'b0;
        ok_en[0] = 1'b1;
        drain(5);
        stop_to_off("fault_clear3");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
